// File: rtl/fsm_multi_dice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fsm_multi_dice
//  Purpose  : Multi-die roller. Debounces a roll/stop button (rs) and a clear
//             button (cl), draws faces 1..6 from a free-running 16-bit LFSR
//             and refreshes them at a programmable step rate. An optional
//             decelerating stop lengthens the refresh period each step before
//             the dice settle.
//  Ports    : clk    - system clock, rising edge
//             reset  - asynchronous, active-low
//             rs     - roll/stop button (raw, active-high)
//             cl     - clear button (raw, active-high)
//             mode   - 0 = instant stop, 1 = decelerating stop
//             led    - 7 pips per die, die k at [7k+6:7k]
//             value  - face 1..6 per die (0 in IDLE), die k at [3k+2:3k]
//             busy   - high while rolling (RUN or SLOW)
//             done   - one-cycle pulse when HOLD is entered
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_multi_dice #(
    parameter int NUM_DICE    = 2,
    parameter int STEP_CYCLES = 2700000,
    parameter int SLOW_STEPS  = 6,
    parameter int DEB_LEN     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rs,
    input  logic                    cl,
    input  logic                    mode,
    output logic [7*NUM_DICE-1:0]   led,
    output logic [3*NUM_DICE-1:0]   value,
    output logic                    busy,
    output logic                    done
);

    localparam int          CW          = $clog2(STEP_CYCLES << SLOW_STEPS);
    localparam int          FW          = $clog2(DEB_LEN + 1);
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SLOW = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    function automatic logic [6:0] pip_decode(input logic [2:0] face);
        logic [6:0] p;
        p = 7'b0000000;
        case (face)
            3'd1:    p = 7'b0001000;
            3'd2:    p = 7'b1000001;
            3'd3:    p = 7'b1001001;
            3'd4:    p = 7'b1100011;
            3'd5:    p = 7'b1101011;
            3'd6:    p = 7'b1110111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Button debounce
    // ------------------------------------------------------------------
    // The filter contents are only trustworthy once DEB_LEN real samples
    // have been shifted in after reset. A button may only produce a press
    // after it has been seen released on real samples, so a button held
    // through reset is not taken as a fresh press.
    logic [FW-1:0] r_fill;
    logic          w_filled;
    logic [1:0]    w_pin;
    logic [1:0]    w_press;

    assign w_filled = (r_fill == FW'(DEB_LEN));
    assign w_pin    = {cl, rs};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill <= '0;
        end else if (!w_filled) begin
            r_fill <= r_fill + FW'(1);
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_btn
            logic [DEB_LEN-1:0] r_sh;
            logic               r_deb;
            logic               r_arm;
            logic               w_all1;
            logic               w_all0;

            assign w_all1 = &r_sh;
            assign w_all0 = ~|r_sh;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sh  <= '0;
                    r_deb <= 1'b0;
                    r_arm <= 1'b0;
                end else begin
                    r_sh <= (r_sh << 1) | DEB_LEN'(w_pin[b]);
                    if (w_all1) begin
                        r_deb <= 1'b1;
                    end else if (w_all0) begin
                        r_deb <= 1'b0;
                    end
                    r_arm <= r_arm | (w_all0 & w_filled);
                end
            end

            // Rising edge of the debounced level, one cycle wide
            assign w_press[b] = w_all1 & ~r_deb & r_arm;
        end
    endgenerate

    logic w_rs_press;
    logic w_cl_press;
    assign w_rs_press = w_press[0];
    assign w_cl_press = w_press[1];

    // ------------------------------------------------------------------
    // Free-running LFSR
    // ------------------------------------------------------------------
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
        end
    end

    // ------------------------------------------------------------------
    // Per-die face draw and pip decode
    // ------------------------------------------------------------------
    logic [3*NUM_DICE-1:0] w_faces;
    logic [3*NUM_DICE-1:0] r_value;

    generate
        for (genvar k = 0; k < NUM_DICE; k++) begin : g_die
            logic [3:0] w_r;
            assign w_r               = r_lfsr[4*k +: 4];
            assign w_faces[3*k +: 3] = 3'(w_r % 4'd6) + 3'd1;
            assign led[7*k +: 7]     = pip_decode(r_value[3*k +: 3]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM and refresh timer
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_n;
    logic        r_done;
    logic [CW:0] w_period_m1;
    logic        w_busy;
    logic        w_tick;
    logic        w_load;

    assign w_busy = (r_state == S_RUN) || (r_state == S_SLOW);

    // SLOW stretches the refresh period to STEP_CYCLES << n
    assign w_period_m1 = ((CW+1)'(STEP_CYCLES) << ((r_state == S_SLOW) ? r_n : 4'd0))
                         - (CW+1)'(1);
    assign w_tick      = w_busy && ({1'b0, r_cnt} == w_period_m1);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rs_press && !w_cl_press) begin
                    w_next = S_RUN;
                    w_load = 1'b1;
                end
            end
            S_RUN: begin
                if (w_cl_press) begin
                    w_next = S_IDLE;
                end else begin
                    w_load = w_tick;
                    if (w_rs_press) begin
                        w_next = mode ? S_SLOW : S_HOLD;
                    end
                end
            end
            S_SLOW: begin
                if (w_cl_press) begin
                    w_next = S_IDLE;
                end else begin
                    w_load = w_tick;
                    if (w_tick && (r_n == 4'(SLOW_STEPS))) begin
                        w_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_cl_press) begin
                    w_next = S_IDLE;
                end else if (w_rs_press) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_n     <= 4'd0;
            r_value <= '0;
            r_done  <= 1'b0;
        end else begin
            if ((w_next != r_state) || !w_busy || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_next != S_SLOW) begin
                r_n <= 4'd0;
            end else if (r_state != S_SLOW) begin
                r_n <= 4'd1;
            end else if (w_tick) begin
                r_n <= r_n + 4'd1;
            end

            if (w_next == S_IDLE) begin
                r_value <= '0;
            end else if (w_load) begin
                r_value <= w_faces;
            end

            r_done <= (w_next == S_HOLD) && (r_state != S_HOLD);
        end
    end

    assign value = r_value;
    assign busy  = w_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fsm_multi_dice.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_multi_dice
//  Purpose  : Self-checking bench for fsm_multi_dice with NUM_DICE=2,
//             STEP_CYCLES=10, SLOW_STEPS=3, DEB_LEN=4. A reference LFSR
//             predicts every loaded face.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_multi_dice;

    logic        clk;
    logic        reset;
    logic        rs;
    logic        cl;
    logic        mode;
    logic [13:0] led;
    logic [5:0]  value;
    logic        busy;
    logic        done;

    int n_chk;
    int n_err;

    fsm_multi_dice #(
        .NUM_DICE   (2),
        .STEP_CYCLES(10),
        .SLOW_STEPS (3),
        .DEB_LEN    (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rs   (rs),
        .cl   (cl),
        .mode (mode),
        .led  (led),
        .value(value),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, shifting right
    function automatic logic [15:0] lstep(input logic [15:0] s);
        logic [15:0] t;
        t = s >> 1;
        if (s[0]) begin
            t[15] = ~t[15];
            t[13] = ~t[13];
            t[12] = ~t[12];
            t[10] = ~t[10];
        end
        return t;
    endfunction

    function automatic logic [2:0] face_of(input logic [3:0] r);
        int f;
        f = (int'(r) % 6) + 1;
        return 3'(f);
    endfunction

    function automatic logic [5:0] faces(input logic [15:0] l);
        return {face_of(l[7:4]), face_of(l[3:0])};
    endfunction

    function automatic logic [6:0] pip(input logic [2:0] f);
        case (f)
            3'd1:    return 7'b0001000;
            3'd2:    return 7'b1000001;
            3'd3:    return 7'b1001001;
            3'd4:    return 7'b1100011;
            3'd5:    return 7'b1101011;
            3'd6:    return 7'b1110111;
            default: return 7'b0000000;
        endcase
    endfunction

    // m_prev holds the LFSR value the DUT used at the most recent edge
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lstep(m_lfsr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_led(input string nm);
        chk(nm, 32'(led), 32'({pip(value[5:3]), pip(value[2:0])}));
    endtask

    typedef struct {
        logic rs;
        logic cl;
        int   cyc;
        logic exp_busy;
        logic exp_zero;
    } vec_t;

    vec_t tbl[13];

    logic [5:0] v;
    logic       in_range;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        rs    = 1'b0;
        cl    = 1'b0;
        mode  = 1'b0;

        tbl[0]  = '{1'b0, 1'b0, 6, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 3, 1'b0, 1'b1};   // glitch shorter than DEB_LEN
        tbl[2]  = '{1'b0, 1'b0, 6, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 5, 1'b1, 1'b0};   // IDLE -> RUN
        tbl[4]  = '{1'b0, 1'b0, 6, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 5, 1'b0, 1'b1};   // cl in RUN -> IDLE
        tbl[6]  = '{1'b0, 1'b0, 6, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 5, 1'b0, 1'b1};   // cl in IDLE ignored
        tbl[8]  = '{1'b0, 1'b0, 6, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 5, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 6, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 5, 1'b0, 1'b1};   // rs+cl together: cl wins
        tbl[12] = '{1'b0, 1'b0, 6, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_led", 32'(led), 0);
        chk("reset_value", 32'(value), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        reset = 1'b1;
        repeat (8) @(negedge clk);

        // Table-driven button sequences
        for (int i = 0; i < 13; i++) begin
            rs = tbl[i].rs;
            cl = tbl[i].cl;
            repeat (tbl[i].cyc) @(negedge clk);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_zero", i), 32'(value == 6'd0), 32'(tbl[i].exp_zero));
            chk_led($sformatf("tbl%0d_led", i));
            if (!tbl[i].exp_zero) begin
                in_range = (value[2:0] >= 3'd1) && (value[2:0] <= 3'd6) &&
                           (value[5:3] >= 3'd1) && (value[5:3] <= 3'd6);
                chk($sformatf("tbl%0d_range", i), 32'(in_range), 1);
            end
        end
        rs = 1'b0;
        cl = 1'b0;

        // Press latency and exact faces on RUN entry
        rs = 1'b1;
        repeat (4) @(negedge clk);
        chk("lat_edge4_busy", 32'(busy), 0);
        @(negedge clk);
        chk("lat_edge5_busy", 32'(busy), 1);
        v = faces(m_prev);
        chk("run_entry_value", 32'(value), 32'(v));
        rs = 1'b0;

        // RUN refresh every 10 cycles, then instant stop
        mode = 1'b0;
        for (int a = 1; a <= 25; a++) begin
            if (a == 21) rs = 1'b1;
            @(negedge clk);
            if (a % 10 == 0) v = faces(m_prev);
            chk($sformatf("run_value_%0d", a), 32'(value), 32'(v));
            if (a == 24) chk("pre_hold_done", 32'(done), 0);
        end
        chk("hold_busy", 32'(busy), 0);
        chk("hold_done_rise", 32'(done), 1);
        chk_led("hold_led");
        rs = 1'b0;
        @(negedge clk);
        chk("hold_done_fall", 32'(done), 0);
        for (int h = 1; h <= 100; h++) begin
            @(negedge clk);
            if (h % 10 == 0) begin
                chk($sformatf("hold_frozen_%0d", h), 32'(value), 32'(v));
                chk($sformatf("hold_busy_%0d", h), 32'(busy), 0);
            end
        end

        // Re-roll from HOLD: faces held for 10 cycles, then refresh
        rs = 1'b1;
        repeat (5) @(negedge clk);
        chk("reroll_busy", 32'(busy), 1);
        chk("reroll_held_value", 32'(value), 32'(v));
        rs = 1'b0;
        for (int a = 1; a <= 15; a++) begin
            if (a == 11) begin
                mode = 1'b1;
                rs   = 1'b1;
            end
            @(negedge clk);
            if (a == 10) v = faces(m_prev);
            chk($sformatf("reroll_value_%0d", a), 32'(value), 32'(v));
        end
        chk("slow_entry_busy", 32'(busy), 1);
        chk("slow_entry_done", 32'(done), 0);
        rs = 1'b0;

        // Decelerating stop: ticks at +20, +60, +140; rs press ignored
        for (int b = 1; b <= 141; b++) begin
            if (b == 50) rs = 1'b1;
            if (b == 60) rs = 1'b0;
            @(negedge clk);
            if (b == 20 || b == 60 || b == 140) v = faces(m_prev);
            chk($sformatf("slow_value_%0d", b), 32'(value), 32'(v));
            if (b == 139) begin
                chk("slow_139_busy", 32'(busy), 1);
                chk("slow_139_done", 32'(done), 0);
            end
            if (b == 140) begin
                chk("slow_hold_busy", 32'(busy), 0);
                chk("slow_hold_done", 32'(done), 1);
            end
            if (b == 141) chk("slow_done_fall", 32'(done), 0);
        end
        chk_led("slow_hold_led");

        // cl in HOLD -> IDLE
        cl = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold_cl_edge4_value", 32'(value), 32'(v));
        @(negedge clk);
        chk("hold_cl_value", 32'(value), 0);
        chk("hold_cl_led", 32'(led), 0);
        cl = 1'b0;
        repeat (6) @(negedge clk);

        // Mid-operation reset with rs held
        rs = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_run_busy", 32'(busy), 1);
        rs = 1'b0;
        repeat (6) @(negedge clk);
        mode = 1'b1;
        rs   = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_slow_busy", 32'(busy), 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_async_value", 32'(value), 0);
        chk("mr_async_led", 32'(led), 0);
        chk("mr_async_busy", 32'(busy), 0);
        chk("mr_async_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("mr_held_not_accepted", 32'(busy), 0);
        chk("mr_held_value", 32'(value), 0);
        rs = 1'b0;
        repeat (4) @(negedge clk);
        rs = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_repress_edge4", 32'(busy), 0);
        @(negedge clk);
        chk("mr_repress_edge5", 32'(busy), 1);
        chk("mr_repress_value", 32'(value), 32'(faces(m_prev)));
        rs = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_multi_dice.md
# fsm_multi_dice

Parametrised multi-die roller: it debounces a roll/stop button (`rs`) and a clear button (`cl`), and drives NUM_DICE 7-pip LED dice. Faces come from a free-running LFSR and refresh at a programmable step rate. An optional decelerating stop makes the dice slow down before they settle. The block is the next generation of the board-level dice FSM: same button semantics, now with N channels, true 1..6 faces, debounced edge detection and a done/busy handshake for downstream score logic.

## Interface
- NUM_DICE, 2, number of dice; legal range 1..4.
- STEP_CYCLES, 2700000, clk cycles per face refresh in RUN (0.05 s at 54 MHz).
- SLOW_STEPS, 6, number of decelerating refreshes in SLOW; legal range 1..8.
- DEB_LEN, 8, consecutive equal samples needed to accept a button level.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low.
- rs  in  1  roll/stop button, active-high, asynchronous to clk.
- cl  in  1  clear button, active-high, asynchronous to clk.
- mode  in  1  0 = instant stop, 1 = decelerating stop; sampled on the rs press in RUN.
- led  out  7*NUM_DICE  pip pattern; die k occupies [7k+6:7k].
- value  out  3*NUM_DICE  face 1..6 per die, 0 in IDLE; die k occupies [3k+2:3k].
- busy  out  1  high in RUN or SLOW.
- done  out  1  one-cycle pulse on the cycle HOLD is entered.

## Operation
- **Debounce**, per button:
  - A DEB_LEN-bit shift register samples the pin every clk.
  - Debounced level `deb` becomes 1 when all bits are 1, and 0 when all bits are 0.
  - press = (all bits 1) & ~deb, evaluated combinationally, so it is high for exactly one cycle per accepted press.
- **LFSR:**
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset.
  - It steps every clk in all states.
  - Die k draws r = lfsr[4k+3:4k] and computes face = (r mod 6)+1.
- **Pip map** (bit 6..0 = TL, TR, ML, C, MR, BL, BR):
  - face 1 = 0001000
  - face 2 = 1000001
  - face 3 = 1001001
  - face 4 = 1100011
  - face 5 = 1101011
  - face 6 = 1110111
  - value 0 = 0000000
- **States:** IDLE, RUN, SLOW, HOLD. Reset state is IDLE.
  - IDLE: rs press → RUN. On that edge, all faces load from the LFSR and the step counter clears. cl is ignored.
  - RUN: cl press → IDLE. rs press → HOLD if mode=0 (done pulses); → SLOW if mode=1 (slow index n=1).
  - SLOW: cl press → IDLE. rs press is ignored. After SLOW_STEPS refreshes → HOLD (done pulses).
  - HOLD: faces are frozen. rs press → RUN (faces keep their held values until the first tick). cl press → IDLE.
- rs and cl pressed on the same cycle: cl wins.
- **Entering IDLE:** value clears to 0 and led clears to 0.
- **Refresh tick:**
  - The step counter runs only in RUN and SLOW, and clears on every state change.
  - RUN: tick when count == STEP_CYCLES-1, then the counter wraps to 0.
  - SLOW: the period is STEP_CYCLES<<n. On each tick the faces reload and n increments. The tick with n == SLOW_STEPS moves to HOLD.
  - Counter width is $clog2(STEP_CYCLES<<SLOW_STEPS).
- **Outputs:**
  - value, n, the counter and state are registers.
  - led is the combinational pip decode of value (no extra latency).
  - busy is decoded from state.
  - done is registered.

## Timing
- Reset values: led=0, value=0, busy=0, done=0, state=IDLE, debounce registers=0, deb=0, LFSR=16'hACE1.
- Button latency: with the pin high from sampling edge 1, press is high after edge DEB_LEN. The state changes on edge DEB_LEN+1.
- Release: the level must be low for DEB_LEN samples before another press can be accepted. Glitches shorter than DEB_LEN cycles are never accepted.
- RUN refresh: the first tick is STEP_CYCLES cycles after entry; ticks repeat every STEP_CYCLES cycles.
- Decelerating stop: HOLD is entered Σ(STEP_CYCLES<<n) cycles after entering SLOW, summed over n=1..SLOW_STEPS.
- done rises on the same edge the state becomes HOLD and falls on the next edge.
- Reset asserted mid-roll forces all registers to reset values immediately; a held-high button is not re-accepted until it is seen released.

## Test plan
Bench parameters: NUM_DICE=2, STEP_CYCLES=10, SLOW_STEPS=3, DEB_LEN=4.

- **Reset and debounce:** release reset; pulse rs high for 3 cycles → state stays IDLE, led=0. Then hold rs high → RUN entered on edge 5; both value fields are in 1..6; busy=1.
- **RUN refresh and instant stop:** in RUN, faces change exactly every 10 cycles. With mode=0, press rs → HOLD, done is a 1-cycle pulse, busy=0, and value/led stay frozen for 100 cycles. Every led field matches the pip map for its value.
- **Decelerating stop:** mode=1, press rs in RUN → SLOW. Ticks occur at +20, +40 (cumulative 60) and +80 (cumulative 140) cycles. HOLD and done arrive on the 140th cycle after SLOW entry. An rs press during SLOW is ignored.
- **Clear priority:** press rs and cl on the same cycle while in RUN → IDLE, value=0, led=0. A cl press in HOLD → IDLE. A cl press in IDLE → no change.
- **Re-roll:** from HOLD, press rs → RUN. Faces hold their previous values for 10 cycles, then refresh.
- **Mid-operation reset:** assert reset during SLOW with rs held high → all outputs are 0 asynchronously. Deassert reset with rs still high → IDLE is kept until rs has been low for 4 cycles and is then pressed again.
